tcdm_sram_responder: RTL and testbench

- Responder (slave) end of the XBAR_TCDM_BUS handshake that the fabric-controller core drives as an initiator.
- Terminates a single TCDM port onto a private word-addressed SRAM bank, with programmable grant wait states and out-of-range error signalling.
- Used as a local L2/private-bank model behind a TCDM master port, and as the standalone responder for core-side bus verification.

---
 rtl/tcdm_resp_pkg.sv | 21 ++
 rtl/tcdm_sram_bank.sv | 30 +++
 rtl/tcdm_sram_responder.sv | 115 +++++++++++
 tb/tb_tcdm_sram_responder.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tcdm_resp_pkg.sv
// Shared types and helpers for the TCDM SRAM responder.
package tcdm_resp_pkg;

  typedef enum logic {IDLE, WAIT} tcdm_fsm_e;

  // Kind of the response currently held on the r_* outputs.
  typedef enum logic [1:0] {RSP_WR, RSP_RD, RSP_ERR} tcdm_rsp_e;

  localparam logic [31:0] ERR_RDATA_DEFAULT = 32'hBADA_CCE5;

  // 32-bit wrapping subtraction so addresses below base land far out of range.
  function automatic logic addr_in_range(input logic [31:0] add, input logic [31:0] base,
                                         input int unsigned words);
    logic [32:0] off;
    logic [32:0] lim;
    off = {1'b0, add - base};
    lim = 33'(words) << 2;
    return off < lim;
  endfunction

endpackage

// File: rtl/tcdm_sram_bank.sv
// Single-port byte-enable SRAM with synchronous read; no reset on the array.
module tcdm_sram_bank #(
  parameter int unsigned MEM_WORDS = 4096,
  parameter int unsigned AW        = $clog2(MEM_WORDS)
) (
  input  logic          clk_i,
  input  logic          en_i,
  input  logic          we_i,
  input  logic [3:0]    be_i,
  input  logic [AW-1:0] addr_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem [MEM_WORDS];

  // rdata_o only moves on a read so it holds between responses.
  always_ff @(posedge clk_i) begin
    if (en_i) begin
      if (we_i) begin
        for (int k = 0; k < 4; k++) begin
          if (be_i[k]) mem[addr_i][8*k +: 8] <= wdata_i[8*k +: 8];
        end
      end else begin
        rdata_o <= mem[addr_i];
      end
    end
  end

endmodule

// File: rtl/tcdm_sram_responder.sv
// TCDM responder: grant wait states, range check and one-cycle response onto a private bank.
module tcdm_sram_responder
  import tcdm_resp_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h1C00_0000,
  parameter int unsigned MEM_WORDS   = 4096,
  parameter int unsigned WAIT_CYCLES = 0,
  parameter logic [31:0] ERR_RDATA   = ERR_RDATA_DEFAULT
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_i,
  input  logic [31:0] add_i,
  input  logic        wen_i,
  input  logic [31:0] wdata_i,
  input  logic [3:0]  be_i,
  output logic        gnt_o,
  output logic        r_valid_o,
  output logic [31:0] r_rdata_o,
  output logic        r_opc_o
);

  localparam int unsigned AW = $clog2(MEM_WORDS);

  logic [31:0]   offset;
  logic          in_range;
  logic [AW-1:0] word_idx;
  logic [31:0]   bank_rdata;
  logic          unused_bits;

  assign offset      = add_i - BASE_ADDR;
  assign in_range    = addr_in_range(add_i, BASE_ADDR, MEM_WORDS);
  assign word_idx    = offset[AW+1:2];
  assign unused_bits = ^{offset[31:AW+2], offset[1:0]};

  generate
    if (WAIT_CYCLES == 0) begin : g_nowait
      assign gnt_o = req_i;
    end else begin : g_wait
      localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES);
      tcdm_fsm_e  state_q, state_d;
      logic [3:0] cnt_q, cnt_d;

      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          state_q <= IDLE;
          cnt_q   <= '0;
        end else begin
          state_q <= state_d;
          cnt_q   <= cnt_d;
        end
      end

      // A dropped request before grant is tolerated by restarting from IDLE.
      always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        gnt_o   = 1'b0;
        case (state_q)
          IDLE: if (req_i) begin
            state_d = WAIT;
            cnt_d   = 4'd1;
          end
          WAIT: if (!req_i) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else if (cnt_q == WAIT_LAST) begin
            gnt_o   = 1'b1;
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d   = cnt_q + 4'd1;
          end
          default: begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        endcase
      end
    end
  endgenerate

  tcdm_sram_bank #(.MEM_WORDS(MEM_WORDS), .AW(AW)) i_bank (
    .clk_i   (clk_i),
    .en_i    (gnt_o & in_range),
    .we_i    (~wen_i),
    .be_i    (be_i),
    .addr_i  (word_idx),
    .wdata_i (wdata_i),
    .rdata_o (bank_rdata)
  );

  // vld_pipe[0] is the grant, vld_pipe[1] the response one cycle later.
  logic [1:0] vld_pipe;
  tcdm_rsp_e  kind_q;

  assign vld_pipe[0] = gnt_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_pipe[1] <= 1'b0;
      kind_q      <= RSP_WR;
    end else begin
      vld_pipe[1] <= vld_pipe[0];
      if (gnt_o) kind_q <= !in_range ? RSP_ERR : (wen_i ? RSP_RD : RSP_WR);
    end
  end

  // kind_q and bank_rdata only change on a grant, so the outputs hold otherwise.
  assign r_valid_o = vld_pipe[1];
  assign r_opc_o   = (kind_q == RSP_ERR);
  assign r_rdata_o = (kind_q == RSP_RD)  ? bank_rdata :
                     (kind_q == RSP_ERR) ? ERR_RDATA  : 32'h0;

endmodule

// File: tb/tb_tcdm_sram_responder.sv
// Scoreboard bench: one responder with no wait states, one with three.
module tb_tcdm_sram_responder;

  localparam logic [31:0] BASE = 32'h1C00_0000;
  localparam int          MW   = 64;
  localparam int          W1   = 3;
  localparam logic [31:0] ERR  = 32'hBADA_CCE5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic req0 = 0, wen0 = 0, gnt0, rv0, opc0;
  logic [31:0] add0 = 0, wd0 = 0, rd0;
  logic [3:0]  be0 = 0;
  logic req1 = 0, wen1 = 0, gnt1, rv1, opc1;
  logic [31:0] add1 = 0, wd1 = 0, rd1;
  logic [3:0]  be1 = 0;

  tcdm_sram_responder #(.BASE_ADDR(BASE), .MEM_WORDS(MW), .WAIT_CYCLES(0)) dut0 (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req0), .add_i(add0), .wen_i(wen0),
    .wdata_i(wd0), .be_i(be0), .gnt_o(gnt0), .r_valid_o(rv0), .r_rdata_o(rd0), .r_opc_o(opc0));

  tcdm_sram_responder #(.BASE_ADDR(BASE), .MEM_WORDS(MW), .WAIT_CYCLES(W1)) dut1 (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req1), .add_i(add1), .wen_i(wen1),
    .wdata_i(wd1), .be_i(be1), .gnt_o(gnt1), .r_valid_o(rv1), .r_rdata_o(rd1), .r_opc_o(opc1));

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0, fails = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at t=%0t", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [31:0] data;
    logic        opc;
    bit          known;
    int          cyc;
  } exp_t;

  exp_t q0[$], q1[$];
  exp_t e0, e1;
  logic [31:0] mdl   [2][MW];
  bit          known [2][MW];

  // Reference: memory as an array of words, range rule as plain wrapping arithmetic.
  function automatic exp_t model(input int d, input logic [31:0] a, input logic rd,
                                 input logic [31:0] wd, input logic [3:0] be, input int rc);
    exp_t e;
    logic [31:0] off;
    int idx;
    off     = a - BASE;
    e.cyc   = rc;
    e.known = 1'b1;
    e.opc   = 1'b0;
    e.data  = 32'h0;
    if (off >= 32'(4 * MW)) begin
      e.opc  = 1'b1;
      e.data = ERR;
    end else begin
      idx = int'(off / 4);
      if (rd) begin
        e.data  = mdl[d][idx];
        e.known = known[d][idx];
      end else begin
        for (int k = 0; k < 4; k++)
          if (be[k]) mdl[d][idx][8*k +: 8] = wd[8*k +: 8];
        if (be == 4'hF) known[d][idx] = 1'b1;
      end
    end
    return e;
  endfunction

  task automatic issue0(input logic [31:0] a, input logic rd, input logic [31:0] wd, input logic [3:0] be);
    exp_t e;
    req0 = 1; add0 = a; wen0 = rd; wd0 = wd; be0 = be;
    e = model(0, a, rd, wd, be, cyc + 1);
    q0.push_back(e);
    @(negedge clk);
    @(posedge clk); #1;
  endtask

  task automatic idle0(input int n);
    repeat (n) begin
      req0 = 0; add0 = $urandom; wd0 = $urandom; be0 = 4'($urandom); wen0 = 1'($urandom);
      @(posedge clk); #1;
    end
  endtask

  task automatic issue1(input logic [31:0] a, input logic rd, input logic [31:0] wd, input logic [3:0] be);
    exp_t e;
    req1 = 1; add1 = a; wen1 = rd; wd1 = wd; be1 = be;
    e = model(1, a, rd, wd, be, cyc + W1 + 1);
    q1.push_back(e);
    for (int k = 0; k <= W1; k++) begin
      @(negedge clk);
      chk("gnt1_wait", {31'b0, gnt1}, {31'b0, k == W1});
      @(posedge clk); #1;
    end
  endtask

  task automatic idle1(input int n);
    repeat (n) begin
      req1 = 0; add1 = $urandom; wd1 = $urandom; be1 = 4'($urandom); wen1 = 1'($urandom);
      @(posedge clk); #1;
    end
  endtask

  function automatic logic [31:0] rand_addr();
    int r;
    r = int'($urandom_range(0, 9));
    if (r < 8) return BASE + 32'(4 * $urandom_range(0, MW - 1)) + 32'($urandom_range(0, 3));
    if (r == 8) return BASE - 32'(4 * $urandom_range(1, 4));
    return $urandom;
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      chk("gnt0", {31'b0, gnt0}, {31'b0, req0});
      if (rv0) begin
        if (q0.size() == 0) chk("unexpected_rvalid0", 32'd1, 32'd0);
        else begin
          e0 = q0.pop_front();
          chk("latency0", 32'(cyc), 32'(e0.cyc));
          chk("opc0", {31'b0, opc0}, {31'b0, e0.opc});
          if (e0.known) chk("rdata0", rd0, e0.data);
        end
      end else if (q0.size() > 0 && q0[0].cyc <= cyc) begin
        e0 = q0.pop_front();
        chk("missing_rvalid0", 32'd0, 32'd1);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (rv1) begin
        if (q1.size() == 0) chk("unexpected_rvalid1", 32'd1, 32'd0);
        else begin
          e1 = q1.pop_front();
          chk("latency1", 32'(cyc), 32'(e1.cyc));
          chk("opc1", {31'b0, opc1}, {31'b0, e1.opc});
          if (e1.known) chk("rdata1", rd1, e1.data);
        end
      end else if (q1.size() > 0 && q1[0].cyc <= cyc) begin
        e1 = q1.pop_front();
        chk("missing_rvalid1", 32'd0, 32'd1);
      end
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_gnt0", {31'b0, gnt0}, 32'd0);
    chk("rst_rvalid0", {31'b0, rv0}, 32'd0);
    chk("rst_rdata0", rd0, 32'd0);
    chk("rst_opc0", {31'b0, opc0}, 32'd0);
    chk("rst_gnt1", {31'b0, gnt1}, 32'd0);
    chk("rst_rvalid1", {31'b0, rv1}, 32'd0);
    chk("rst_rdata1", rd1, 32'd0);
    @(negedge clk) rst_n = 1;
    @(posedge clk); #1;

    // Basic write/read and byte enables.
    issue0(BASE + 32'h10, 1'b0, 32'hDEAD_BEEF, 4'hF);
    issue0(BASE + 32'h10, 1'b1, 32'h0, 4'h0);
    issue0(BASE + 32'h20, 1'b0, 32'h1122_3344, 4'hF);
    issue0(BASE + 32'h20, 1'b0, 32'hAABB_CCDD, 4'b0101);
    issue0(BASE + 32'h20, 1'b1, 32'h0, 4'h0);
    issue0(BASE + 32'h20, 1'b0, 32'hFFFF_FFFF, 4'h0);
    issue0(BASE + 32'h22, 1'b1, 32'h0, 4'h0);

    // Range edges: last and first word, then just past each end.
    issue0(BASE + 32'(4 * (MW - 1)), 1'b0, 32'h5A5A_0001, 4'hF);
    issue0(BASE, 1'b0, 32'hA5A5_0000, 4'hF);
    issue0(BASE + 32'(4 * MW), 1'b1, 32'h0, 4'h0);
    issue0(BASE - 32'd4, 1'b0, 32'h1234_5678, 4'hF);
    issue0(BASE + 32'(4 * (MW - 1)), 1'b1, 32'h0, 4'h0);
    issue0(BASE, 1'b1, 32'h0, 4'h0);
    idle0(2);

    // 16 writes then 16 reads with req held high.
    for (int i = 0; i < 16; i++) issue0(BASE + 32'(4 * (8 + i)), 1'b0, $urandom, 4'hF);
    for (int i = 0; i < 16; i++) issue0(BASE + 32'(4 * (8 + i)), 1'b1, $urandom, 4'($urandom));
    idle0(1);

    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 3) == 0) idle0(int'($urandom_range(1, 2)));
      issue0(rand_addr(), 1'($urandom), $urandom, 4'($urandom));
    end
    idle0(2);

    // Wait-state responder: back-to-back, then request dropped and re-asserted.
    issue1(BASE + 32'h10, 1'b0, 32'hDEAD_BEEF, 4'hF);
    issue1(BASE + 32'h10, 1'b1, 32'h0, 4'h0);
    issue1(BASE + 32'(4 * MW), 1'b1, 32'h0, 4'h0);
    idle1(1);
    req1 = 1; add1 = BASE + 32'h10; wen1 = 1;
    for (int k = 0; k < 3; k++) begin
      if (k == 2) req1 = 0;
      @(negedge clk);
      chk("gnt1_abort", {31'b0, gnt1}, 32'd0);
      @(posedge clk); #1;
    end
    issue1(BASE + 32'h10, 1'b1, 32'h0, 4'h0);
    idle1(1);
    for (int i = 0; i < 20; i++) begin
      if ($urandom_range(0, 2) == 0) idle1(1);
      issue1(rand_addr(), 1'($urandom), $urandom, 4'($urandom));
    end
    idle1(3);

    // Reset in the cycle after a read grant drops the response.
    issue0(BASE + 32'h40, 1'b0, 32'hC0FF_EE11, 4'hF);
    issue0(BASE + 32'h40, 1'b1, 32'h0, 4'h0);
    q0.pop_back();
    rst_n = 0; req0 = 0;
    #1;
    chk("rstmid_rvalid0", {31'b0, rv0}, 32'd0);
    chk("rstmid_rdata0", rd0, 32'd0);
    chk("rstmid_opc0", {31'b0, opc0}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1;
    repeat (4) begin
      @(posedge clk); #1;
      chk("post_rst_rvalid0", {31'b0, rv0}, 32'd0);
    end
    issue0(BASE + 32'h40, 1'b1, 32'h0, 4'h0);
    issue0(BASE + 32'h10, 1'b1, 32'h0, 4'h0);
    idle0(1);
    issue1(BASE + 32'h10, 1'b1, 32'h0, 4'h0);
    idle1(3);
    idle0(2);

    chk("q0_drained", 32'(q0.size()), 32'd0);
    chk("q1_drained", 32'(q1.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
